if_id_buffer: RTL and testbench

Two-entry IF/ID pipeline buffer sitting directly downstream of the PC datapath and instruction memory. It captures each fetched {PC, instruction} pair and presents it in order to the decode stage over a valid/ready handshake. It back-pressures the PC stage when both slots are occupied. On a taken branch it squashes every buffered instruction so that wrong-path instructions never reach decode.

---
 rtl/if_id_buffer_pkg.sv | 18 +
 rtl/if_id_buffer_if.sv | 23 ++
 rtl/if_id_buffer_slot.sv | 25 ++
 rtl/if_id_buffer.sv | 99 +++++++++
 tb/tb_if_id_buffer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared constants and entry type for the IF/ID buffer.
// Entries carry the fetched PC together with its instruction word.
package ifid_pkg;
  localparam logic [31:0] NOP_INSTR  = 32'hD503201F;
  localparam int          IFID_DEPTH = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ifid_entry_t;

  function automatic ifid_entry_t empty_entry(input logic [31:0] nop);
    ifid_entry_t e;
    e.pc    = 64'd0;
    e.instr = nop;
    return e;
  endfunction
endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID buffer.
// slave = buffer view, master = fetch/decode environment view.
interface if_id_buffer_if;
  logic [63:0] pc_in;
  logic [31:0] instr_in;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;

  modport slave (
    input  pc_in, instr_in, fetch_valid, flush, id_ready,
    output fetch_ready, id_valid, id_pc, id_instr
  );

  modport master (
    output pc_in, instr_in, fetch_valid, flush, id_ready,
    input  fetch_ready, id_valid, id_pc, id_instr
  );
endinterface

// File: rtl/if_id_buffer_slot.sv
// One buffer slot: 96-bit enable-gated register, async active-low reset to {0, NOP}.
// Latency: written value visible after the enabling edge. No backpressure of its own.
module ifid_slot
  import ifid_pkg::*;
#(
  parameter logic [31:0] RST_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  ifid_entry_t d_i,
  output ifid_entry_t q_o
);
  ifid_entry_t dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_q <= empty_entry(RST_INSTR);
    end else if (we_i) begin
      dat_q <= d_i;
    end
  end

  assign q_o = dat_q;
endmodule

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID buffer: in-order {PC, instr} hand-off with flush squashing all entries.
// Latency 1 cycle fetch->decode; fetch_ready is registered-only (low when both slots full).
// Optional IFID_PERF_CNT_EN adds saturating stall/flush counters.
module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic            clk,
  input  logic            reset,
  if_id_buffer_if.slave   bus
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);
  import ifid_pkg::*;

  localparam logic [1:0] FULL = DEPTH[1:0];

  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        push, pop;
  ifid_entry_t wr_dat;
  ifid_entry_t slot_q [2];
  ifid_entry_t head;

  assign bus.fetch_ready = (count_q != FULL);
  assign bus.id_valid    = (count_q != 2'd0);

  assign push = bus.fetch_valid && bus.fetch_ready && !bus.flush;
  assign pop  = bus.id_valid && bus.id_ready && !bus.flush;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign wr_dat.pc    = bus.pc_in;
  assign wr_dat.instr = bus.instr_in;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    ifid_slot #(.RST_INSTR(NOP_INSTR)) u_slot (
      .clk   (clk),
      .rst_n (reset),
      .we_i  (push && (wr_ptr_q == 1'(i))),
      .d_i   (wr_dat),
      .q_o   (slot_q[i])
    );
  end

  assign head         = slot_q[rd_ptr_q];
  // Empty buffer presents a bubble rather than stale slot contents.
  assign bus.id_pc    = bus.id_valid ? head.pc    : 64'd0;
  assign bus.id_instr = bus.id_valid ? head.instr : NOP_INSTR;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (bus.fetch_valid && !bus.fetch_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.flush && bus.id_valid && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: queue-based reference model checked every negedge,
// directed literal checks, then randomized traffic with sporadic flushes.
module tb_if_id_buffer;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  if_id_buffer_if bus();

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  if_id_buffer dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of buffered {pc, instr} entries.
  logic [95:0] mq[$];
  longint      m_stall = 0;
  longint      m_flush = 0;

  always @(negedge rst_n) begin
    mq.delete();
    m_stall = 0;
    m_flush = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit full  = (mq.size() == 2);
      automatic bit empty = (mq.size() == 0);
      if (bus.fetch_valid && full) m_stall++;
      if (bus.flush) begin
        if (!empty) m_flush++;
        mq.delete();
      end else begin
        if (bus.id_ready && !empty) void'(mq.pop_front());
        if (bus.fetch_valid && !full) mq.push_back({bus.pc_in, bus.instr_in});
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [63:0] epc;
    logic [31:0] ein;
    epc = (mq.size() != 0) ? mq[0][95:32] : 64'd0;
    ein = (mq.size() != 0) ? mq[0][31:0]  : NOP;
    chk({tag, ".id_valid"},    64'(bus.id_valid),    64'(mq.size() != 0));
    chk({tag, ".fetch_ready"}, 64'(bus.fetch_ready), 64'(mq.size() != 2));
    chk({tag, ".id_pc"},       bus.id_pc,            epc);
    chk({tag, ".id_instr"},    64'(bus.id_instr),    64'(ein));
`ifdef IFID_PERF_CNT_EN
    chk({tag, ".stall_cnt"},   64'(stall_cnt),       64'(m_stall));
    chk({tag, ".flush_cnt"},   64'(flush_cnt),       64'(m_flush));
`endif
  endtask

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) chk_model("model");

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit fv, input logic [63:0] pc, input bit rdy, input bit fl);
    bus.fetch_valid = fv;
    bus.pc_in       = pc;
    bus.instr_in    = pc[31:0] ^ 32'hA5A5_0000;
    bus.id_ready    = rdy;
    bus.flush       = fl;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 64'h100, 1'b1, 1'b0);
    #2;
    chk("rst.id_valid",    64'(bus.id_valid),    64'd0);
    chk("rst.fetch_ready", 64'(bus.fetch_ready), 64'd1);
    chk("rst.id_pc",       bus.id_pc,            64'd0);
    chk("rst.id_instr",    64'(bus.id_instr),    64'hD503201F);
    cyc(2);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1);

    // Streaming: each fetch appears one cycle later, buffer never fills.
    drive(1'b1, 64'h0, 1'b1, 1'b0); cyc(1);
    chk("stream.pc0", bus.id_pc, 64'h0);
    chk("stream.v0",  64'(bus.id_valid), 64'd1);
    drive(1'b1, 64'h4, 1'b1, 1'b0); cyc(1);
    chk("stream.pc4", bus.id_pc, 64'h4);
    chk("stream.rdy", 64'(bus.fetch_ready), 64'd1);
    drive(1'b1, 64'h8, 1'b1, 1'b0); cyc(1);
    chk("stream.pc8", bus.id_pc, 64'h8);
    drive(1'b0, 64'h0, 1'b1, 1'b0); cyc(1);
    chk("stream.drain", 64'(bus.id_valid), 64'd0);

    // Back-pressure.
    drive(1'b1, 64'h10, 1'b0, 1'b0); cyc(1);
    chk("bp.rdy_after1", 64'(bus.fetch_ready), 64'd1);
    drive(1'b1, 64'h14, 1'b0, 1'b0); cyc(1);
    chk("bp.full",   64'(bus.fetch_ready), 64'd0);
    chk("bp.head",   bus.id_pc, 64'h10);
    drive(1'b1, 64'h18, 1'b0, 1'b0); cyc(1);
    chk("bp.ignored", bus.id_pc, 64'h10);
    chk("bp.still_full", 64'(bus.fetch_ready), 64'd0);
    drive(1'b0, 64'h0, 1'b1, 1'b0); cyc(1);
    chk("bp.pop1", bus.id_pc, 64'h14);
    chk("bp.ready_back", 64'(bus.fetch_ready), 64'd1);
    cyc(1);
    chk("bp.empty", 64'(bus.id_valid), 64'd0);

    // Flush at count 2 with concurrent push and ready.
    drive(1'b1, 64'h30, 1'b0, 1'b0); cyc(1);
    drive(1'b1, 64'h34, 1'b0, 1'b0); cyc(1);
    drive(1'b1, 64'h40, 1'b1, 1'b1); cyc(1);
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    chk("flush.valid", 64'(bus.id_valid), 64'd0);
    chk("flush.instr", 64'(bus.id_instr), 64'hD503201F);
    cyc(1);
    chk("flush.no40", 64'(bus.id_valid), 64'd0);

    // Push + pop at count 1 keeps one entry in order.
    drive(1'b1, 64'h50, 1'b1, 1'b0); cyc(1);
    drive(1'b1, 64'h54, 1'b1, 1'b0); cyc(1);
    chk("pp.pc54", bus.id_pc, 64'h54);
    chk("pp.ready", 64'(bus.fetch_ready), 64'd1);
    drive(1'b1, 64'h58, 1'b0, 1'b0); cyc(1);
    chk("pp.full", 64'(bus.fetch_ready), 64'd0);

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 64'(bus.id_valid),    64'd0);
    chk("arst.ready", 64'(bus.fetch_ready), 64'd1);
    chk("arst.pc",    bus.id_pc,            64'd0);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    cyc(1);
    rst_n = 1'b1;
    drive(1'b1, 64'h60, 1'b0, 1'b0); cyc(1);
    chk("arst.first_push", bus.id_pc, 64'h60);

`ifdef IFID_PERF_CNT_EN
    drive(1'b1, 64'h64, 1'b0, 1'b0); cyc(1);
    cyc(3);
    drive(1'b0, 64'h0, 1'b0, 1'b1); cyc(1);
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("perf.stall", 64'(stall_cnt), 64'd3);
    chk("perf.flush", 64'(flush_cnt), 64'd1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0,
            {$urandom(), $urandom() & 32'hFFFF_FFFC},
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      cyc(1);
    end
    drive(1'b0, 64'h0, 1'b1, 1'b0);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
